// File: rtl/dm_responder.sv
// Word-organised data RAM responder: lane-masked writes, lane-selected sign/zero-extended reads.
// Response appears WAIT+2 cycles after accept; a new request is only granted in IDLE or RESP.
module dm_responder #(
   parameter int ADDR_W = 12,
   parameter int WAIT   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [31:0] addr,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   input  logic [2:0]  deop,
   output logic        gnt,
   output logic        busy,
   output logic        rvalid,
   output logic [31:0] rdata,
   output logic        err
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t            state, state_nxt;
   logic [2:0]        cnt;
   logic [31:0]       addr_q, wdata_q;
   logic [3:0]        byteen_q;
   logic [2:0]        deop_q;
   logic [31:0]       mem [2**ADDR_W];
   logic [ADDR_W-1:0] idx;
   logic              do_access, is_wr, be_ok, align_err, acc_err;
   logic [31:0]       word, ext_data;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;

   assign gnt       = req & (state == ST_IDLE | state == ST_RESP);
   assign busy      = (state == ST_WAIT);
   assign rvalid    = (state == ST_RESP);
   assign do_access = (state == ST_WAIT) && (cnt == 3'd0);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req) state_nxt = ST_WAIT;
         ST_WAIT: if (cnt == 3'd0) state_nxt = ST_RESP;
         ST_RESP: state_nxt = req ? ST_WAIT : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         if (gnt)
            cnt <= 3'(WAIT);
         else if (busy && cnt != 3'd0)
            cnt <= cnt - 3'd1;
      end
   end

   // Request registers deliberately carry no reset; they are only consumed after an accept.
   always_ff @(posedge clk) begin
      if (gnt) begin
         addr_q   <= addr;
         byteen_q <= byteen;
         wdata_q  <= wdata;
         deop_q   <= deop;
      end
   end

   always_comb begin
      idx   = addr_q[ADDR_W+1:2];
      word  = mem[idx];
      is_wr = |byteen_q;
      case (byteen_q)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
         default:                   be_ok = 1'b0;
      endcase
      case (deop_q)
         3'd1, 3'd2: align_err = 1'b0;
         3'd3, 3'd4: align_err = addr_q[0];
         default:    align_err = (addr_q[1:0] != 2'b00);
      endcase
      acc_err = (|addr_q[31:ADDR_W+2]) | (is_wr ? !be_ok : align_err);
      case (addr_q[1:0])
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = addr_q[1] ? word[31:16] : word[15:0];
      case (deop_q)
         3'd1:    ext_data = {24'b0, byte_sel};
         3'd2:    ext_data = {{24{byte_sel[7]}}, byte_sel};
         3'd3:    ext_data = {16'b0, half_sel};
         3'd4:    ext_data = {{16{half_sel[15]}}, half_sel};
         default: ext_data = word;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_access && is_wr && !acc_err) begin
         for (int i = 0; i < 4; i++)
            if (byteen_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= 32'd0;
         err   <= 1'b0;
      end else if (do_access) begin
         err   <= acc_err;
         rdata <= (acc_err || is_wr) ? 32'd0 : ext_data;
      end
   end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the M-stage memory interface: the far end of the store byte-enable path. It accepts byte-lane-positioned write requests (byteen + replicated wdata) and read requests, runs a fixed programmable wait-state sequence, then performs the RAM access. It returns load data already lane-selected and sign/zero-extended per the load type. It sits between the CPU M-stage bus port and the word-organised data RAM, and models the multi-cycle memory that the pipeline stalls on.

## Interface
- ADDR_W, 12: word-address width; RAM holds 2^ADDR_W 32-bit words.
- WAIT, 1: wait-state cycles per access, legal 0..7.

- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  1  request valid
- addr  input  32  byte address
- byteen  input  4  write lane mask; 4'b0000 = read
- wdata  input  32  write data, already lane-positioned/replicated
- deop  input  3  load extension: 0 LW, 1 LBU, 2 LB, 3 LHU, 4 LH; others treated as LW
- gnt  output  1  request accepted on this edge (combinational)
- busy  output  1  access in flight (state WAIT)
- rvalid  output  1  one-cycle response pulse, reads and writes
- rdata  output  32  extended load data; 0 on writes and errors
- err  output  1  response is an error; valid only with rvalid

## Operation
- FSM states IDLE, WAIT, RESP. gnt = req & (state==IDLE | state==RESP).
- Accept (gnt=1 at edge): capture addr, byteen, wdata, deop into request registers; cnt <= WAIT; state <= WAIT.
- WAIT: if cnt!=0, cnt <= cnt-1; else perform access, register rdata/err, state <= RESP.
- RESP: rvalid=1 for this cycle. Next state WAIT if new request accepted, else IDLE.
- Word index = addr[ADDR_W+1:2]. addr[31:ADDR_W+2] nonzero -> err.
- Read alignment: LW needs addr[1:0]==0; LH/LHU need addr[0]==0; else err.
- Legal byteen: 0001, 0010, 0100, 1000, 0011, 1100, 1111; any other nonzero mask -> err.
- Error access: RAM untouched, rdata=0, err=1.
- Write: for each lane i with byteen[i]=1, mem[idx][8i+7:8i] <= wdata[8i+7:8i]; other lanes keep old value; rdata=0.
- Read: byte = word lane addr[1:0]; half = addr[1] ? word[31:16] : word[15:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes word.
- RAM contents are not reset. The request registers are not reset.

## Timing
- Reset values: state IDLE, cnt 0, rvalid 0, rdata 0, err 0, busy 0. gnt follows req.
- Latency: accept at edge E0; access at edge E0+WAIT+1; rvalid high in the cycle after that edge.
- Throughput: with req held high, one response every WAIT+2 cycles. A new request is accepted in the RESP cycle.
- Write followed by read of the same word returns the new data. The write completes at its access edge, before the read can be accepted.
- Reset asserted in WAIT: the pending access is dropped, no RAM write occurs, and no rvalid is issued.
- Reset asserted in RESP: rvalid/rdata/err clear immediately. A write already performed persists.
- addr/byteen/wdata/deop may change after accept without effect.

## Test plan
- Reset: reset=0 with req=0 -> rvalid=0, busy=0, rdata=0, err=0. Release, req=1 -> gnt=1 immediately.
- SW then LW, WAIT=1: write 0x12345678 at 0x10, byteen 1111 -> rvalid 3 edges after accept, err=0. Then LW 0x10 -> rdata 0x12345678.
- SB then loads: wdata 0xABABABAB, byteen 0100, addr 0x12. Then LB 0x12 -> 0xFFFFFFAB; LBU 0x12 -> 0x000000AB; LW 0x10 -> 0x12AB5678.
- SH then half loads: wdata 0x80018001, byteen 1100, addr 0x12. Then LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001.
- Errors:
  - LW at 0x13 -> err=1, rdata=0.
  - byteen 0110 at 0x10 -> err=1; LW 0x10 still returns the old word.
  - addr 0x00004000 (ADDR_W=12) -> err=1.
- Back-to-back and reset mid-access:
  - req held high for 3 requests, WAIT=0 -> rvalid pulses every 2 cycles.
  - Write 0xDEADBEEF to 0x20, WAIT=3, reset pulsed in the 2nd WAIT cycle -> no rvalid; LW 0x20 returns the prior value.
